// File: rtl/nbody_integrate_seq.sv
// Integration sequencer: walks every body/axis and issues vel+=acc*dt and pos+=vel*dt to an
// external fixed-latency multiply-add, writing results back through a tag delay line.
module nbody_integrate_seq #(
    parameter int unsigned MAX_BODIES = 10,
    parameter int unsigned DIMS       = 3,
    parameter int unsigned MAC_LAT    = 4,
    parameter int unsigned OFF_NUM    = 1,
    parameter int unsigned OFF_POS    = 23,
    parameter int unsigned OFF_VEL    = 53,
    parameter int unsigned OFF_ACC    = 83
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        MODE,
    input  logic        clr_acc_en,
    input  logic [31:0] dt,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        mac_valid_in,
    output logic [31:0] mac_a,
    output logic [31:0] mac_b,
    output logic [31:0] mac_c,
    input  logic [31:0] mac_result,
    output logic        BUSY,
    output logic        DONE
);
    localparam int unsigned IW = $clog2(MAX_BODIES + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_NUM,
        S_LOAD_NUM,
        S_RD_A,
        S_RD_C,
        S_ISSUE,
        S_DRAIN,
        S_CLR,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      n_q, n_d, i_q, i_d;
    logic [1:0]         d_q, d_d;
    logic               phase_q, phase_d;
    logic               mode_q, mode_d;
    logic               clr_q, clr_d;
    logic [31:0]        dt_q, dt_d;
    logic [31:0]        src_q, src_d;
    logic [MAC_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [31:0]        tag_addr_q [MAC_LAT];
    logic [31:0]        tag_addr_d [MAC_LAT];

    logic               vel_phase, last_elem, last_dim;
    logic [IW-1:0]      n_clamp, i_next;
    logic [1:0]         d_next;
    logic [31:0]        src_base, dst_base, src_addr, dst_addr, acc_addr;

    function automatic logic [31:0] elem_addr(input logic [31:0] base, input logic [1:0] d,
                                              input logic [IW-1:0] i);
        return base + 32'(d) * MAX_BODIES + 32'(i) + 32'd1;
    endfunction

    // phase 0 is VEL when MODE=0, POS when MODE=1
    assign vel_phase = (phase_q == mode_q);
    assign src_base  = vel_phase ? OFF_ACC : OFF_VEL;
    assign dst_base  = vel_phase ? OFF_VEL : OFF_POS;
    assign src_addr  = elem_addr(src_base, d_q, i_q);
    assign dst_addr  = elem_addr(dst_base, d_q, i_q);
    assign acc_addr  = elem_addr(OFF_ACC, d_q, i_q);

    assign n_clamp   = (rd_data > MAX_BODIES) ? IW'(MAX_BODIES) : rd_data[IW-1:0];
    assign last_dim  = (32'(d_q) + 32'd1 == DIMS);
    assign last_elem = last_dim && (32'(i_q) + 32'd1 == 32'(n_q));
    assign d_next    = last_dim ? 2'd0 : d_q + 2'd1;
    assign i_next    = last_dim ? i_q + 1'b1 : i_q;

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        i_d          = i_q;
        d_d          = d_q;
        phase_d      = phase_q;
        mode_d       = mode_q;
        clr_d        = clr_q;
        dt_d         = dt_q;
        src_d        = src_q;
        rd_addr      = '0;
        mac_valid_in = 1'b0;
        mac_a        = '0;
        mac_b        = '0;
        mac_c        = '0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    mode_d  = MODE;
                    clr_d   = clr_acc_en;
                    dt_d    = dt;
                    state_d = S_RD_NUM;
                end
            end
            S_RD_NUM: begin
                rd_addr = OFF_NUM;
                state_d = S_LOAD_NUM;
            end
            S_LOAD_NUM: begin
                n_d     = n_clamp;
                i_d     = '0;
                d_d     = '0;
                phase_d = 1'b0;
                state_d = (n_clamp == '0) ? S_DONE : S_RD_A;
            end
            S_RD_A: begin
                rd_addr = src_addr;
                state_d = S_RD_C;
            end
            S_RD_C: begin
                rd_addr = dst_addr;
                src_d   = rd_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                mac_valid_in = 1'b1;
                mac_a        = src_q;
                mac_b        = dt_q;
                mac_c        = rd_data;
                if (last_elem) begin
                    state_d = S_DRAIN;
                end else begin
                    i_d     = i_next;
                    d_d     = d_next;
                    state_d = S_RD_A;
                end
            end
            S_DRAIN: begin
                // next phase may only read once every write of this one has landed
                if (tag_vld_q == '0) begin
                    i_d = '0;
                    d_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        state_d = S_RD_A;
                    end else if (clr_q) begin
                        state_d = S_CLR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_CLR: begin
                if (last_elem) begin
                    state_d = S_DONE;
                end else begin
                    i_d = i_next;
                    d_d = d_next;
                end
            end
            S_DONE: begin
                if (!START) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tag_vld_d     = '0;
        tag_vld_d[0]  = mac_valid_in;
        tag_addr_d[0] = dst_addr;
        for (int k = 1; k < MAC_LAT; k++) begin
            tag_vld_d[k]  = tag_vld_q[k-1];
            tag_addr_d[k] = tag_addr_q[k-1];
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (tag_vld_q[MAC_LAT-1]) begin
            wr_en   = 1'b1;
            wr_addr = tag_addr_q[MAC_LAT-1];
            wr_data = mac_result;
        end else if (state_q == S_CLR) begin
            wr_en   = 1'b1;
            wr_addr = acc_addr;
        end
    end

    assign BUSY = (state_q != S_IDLE) && (state_q != S_DONE);
    assign DONE = (state_q == S_DONE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            i_q       <= '0;
            d_q       <= '0;
            phase_q   <= 1'b0;
            mode_q    <= 1'b0;
            clr_q     <= 1'b0;
            dt_q      <= '0;
            src_q     <= '0;
            tag_vld_q <= '0;
            for (int k = 0; k < MAC_LAT; k++) tag_addr_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            i_q       <= i_d;
            d_q       <= d_d;
            phase_q   <= phase_d;
            mode_q    <= mode_d;
            clr_q     <= clr_d;
            dt_q      <= dt_d;
            src_q     <= src_d;
            tag_vld_q <= tag_vld_d;
            for (int k = 0; k < MAC_LAT; k++) tag_addr_q[k] <= tag_addr_d[k];
        end
    end

endmodule

// File: tb/tb_nbody_integrate_seq.sv
// Bench for nbody_integrate_seq: datafile and MAC models, expected writes queued per run and
// checked by a write monitor.
module tb_nbody_integrate_seq;
    localparam logic [31:0] ONE  = 32'h3F80_0000;
    localparam logic [31:0] NEG  = 32'hBF80_0000;
    localparam logic [31:0] ZERO = 32'h0000_0000;
    localparam int          LAT  = 4;

    logic        CLK = 1'b0, RESET = 1'b1, START = 1'b0, MODE = 1'b0, clr_acc_en = 1'b0;
    logic [31:0] dt = ONE;
    logic [31:0] rd_addr, rd_data, wr_addr, wr_data, mac_a, mac_b, mac_c, mac_result;
    logic        wr_en, mac_valid_in, BUSY, DONE;

    logic [31:0] mem [128];
    logic [31:0] pipe_r [LAT];

    int total = 0, bad = 0, cyc = 0;
    int wr_cnt = 0, mac_cnt = 0, last_wr_cyc = 0, last_mac_cyc = 0, mac_base = 0, per_phase = 0;
    int run_wr, run_mac, pos_rd_wr, done_gap;
    bit sb_on = 1'b0;

    typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t e_mon;

    // case-1 destinations: vel b0 x,y,z, vel b1 x,y,z, pos b0 x,y,z, pos b1 x,y,z
    logic [31:0] c_addr [12] = '{32'd54, 32'd64, 32'd74, 32'd55, 32'd65, 32'd75,
                                 32'd24, 32'd34, 32'd44, 32'd25, 32'd35, 32'd45};
    logic [31:0] vel_v  [6]  = '{ZERO, ONE, ONE, ZERO, NEG, NEG};
    logic [31:0] pos0_v [6]  = '{ONE, ONE, ONE, NEG, NEG, NEG};
    logic [31:0] pos1_v [6]  = '{ONE, ONE, ZERO, NEG, NEG, ZERO};
    logic [31:0] clr_a  [6]  = '{32'd84, 32'd94, 32'd104, 32'd85, 32'd95, 32'd105};

    nbody_integrate_seq dut (
        .CLK(CLK), .RESET(RESET), .START(START), .MODE(MODE), .clr_acc_en(clr_acc_en), .dt(dt),
        .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mac_valid_in(mac_valid_in), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_result(mac_result), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    function automatic real fp2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:0] == 31'd0) return 0.0;
        e = int'(b[30:23]) - 127;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** e);
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2fp(input real r);
        real         a;
        int          e;
        logic [22:0] m;
        if (r == 0.0) return 32'h0;
        a = (r < 0.0) ? -r : r;
        e = 0;
        for (int k = 0; k < 300 && a >= 2.0; k++) begin a = a / 2.0; e++; end
        for (int k = 0; k < 300 && a < 1.0; k++) begin a = a * 2.0; e--; end
        m = 23'($rtoi((a - 1.0) * 8388608.0 + 0.5));
        return {(r < 0.0), 8'(e + 127), m};
    endfunction

    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        rd_data <= mem[rd_addr[6:0]];
        if (wr_en) mem[wr_addr[6:0]] <= wr_data;
        pipe_r[0] <= mac_valid_in ? r2fp(fp2r(mac_a) * fp2r(mac_b) + fp2r(mac_c)) : 32'h0;
        for (int k = 1; k < LAT; k++) pipe_r[k] <= pipe_r[k-1];
    end
    assign mac_result = pipe_r[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // write/issue monitor
    always @(negedge CLK) begin
        if (wr_en) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_wr: got addr %h data %h want no write", wr_addr, wr_data);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("wr_addr", wr_addr, e_mon.a);
                    check("wr_data", wr_data, e_mon.d);
                end
            end
        end
        if (mac_valid_in) begin
            if (per_phase > 0 && ((mac_cnt - mac_base) % per_phase) != 0)
                check("mac_gap", 32'(cyc - last_mac_cyc), 32'd3);
            last_mac_cyc = cyc;
            mac_cnt++;
        end
    end

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic load_case1();
        for (int k = 0; k < 128; k++) mem[k] = 32'h0;
        mem[1]   = 32'd2;
        mem[24]  = ONE;
        mem[25]  = NEG;
        mem[64]  = ONE;
        mem[65]  = NEG;
        mem[104] = ONE;
        mem[105] = NEG;
    endtask

    task automatic push_case1(input bit mode);
        if (!mode) begin
            for (int k = 0; k < 6; k++) push_wr(c_addr[k], vel_v[k]);
            for (int k = 0; k < 6; k++) push_wr(c_addr[k+6], pos0_v[k]);
        end else begin
            for (int k = 0; k < 6; k++) push_wr(c_addr[k+6], pos1_v[k]);
            for (int k = 0; k < 6; k++) push_wr(c_addr[k], vel_v[k]);
        end
    endtask

    task automatic check_case1_mem(input bit mode, input bit cleared);
        for (int k = 0; k < 6; k++) begin
            check("mem_vel", mem[c_addr[k]], vel_v[k]);
            check("mem_pos", mem[c_addr[k+6]], mode ? pos1_v[k] : pos0_v[k]);
        end
        check("mem_acc0z", mem[104], cleared ? ZERO : ONE);
        check("mem_acc1z", mem[105], cleared ? ZERO : NEG);
    endtask

    task automatic run(input bit mode, input bit clr, input int pp);
        int  wr0, mac0;
        bit  done_seen;
        per_phase  = pp;
        mac_base   = mac_cnt;
        wr0        = wr_cnt;
        mac0       = mac_cnt;
        pos_rd_wr  = -1;
        done_seen  = 1'b0;
        MODE       = mode;
        clr_acc_en = clr;
        dt         = ONE;
        START      = 1'b1;
        for (int t = 0; t < 3000 && !done_seen; t++) begin
            @(negedge CLK);
            if (pos_rd_wr < 0 && BUSY && rd_addr >= 32'd24 && rd_addr <= 32'd45)
                pos_rd_wr = wr_cnt - wr0;
            if (DONE) begin
                done_seen = 1'b1;
                done_gap  = cyc - last_wr_cyc;
            end
        end
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got no DONE want DONE within 3000 cycles");
        end
        MODE       = ~mode;
        clr_acc_en = ~clr;
        dt         = 32'h4000_0000;
        run_wr     = wr_cnt - wr0;
        run_mac    = mac_cnt - mac0;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic finish_run();
        START = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int busy_seen, wr_seen, issued;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_outs", {rd_addr | wr_addr | wr_data | mac_a | mac_b | mac_c}, 32'h0);
        check("rst_flags", {28'h0, wr_en, mac_valid_in, BUSY, DONE}, 32'h0);
        RESET = 1'b0;
        @(negedge CLK);
        sb_on = 1'b1;

        // case 1: semi-implicit
        load_case1();
        push_case1(1'b0);
        run(1'b0, 1'b0, 6);
        check("c1_writes", 32'(run_wr), 32'd12);
        check("c1_macs", 32'(run_mac), 32'd12);
        check("c1_pos_rd_after_vel", 32'(pos_rd_wr), 32'd6);
        check("c1_done", {31'h0, DONE}, 32'd1);
        check_case1_mem(1'b0, 1'b0);
        busy_seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (BUSY || mac_valid_in || !DONE) busy_seen++;
        end
        check("hold_no_restart", 32'(busy_seen), 32'd0);
        finish_run();
        check("done_drop", {31'h0, DONE}, 32'd0);

        // case 2: explicit
        load_case1();
        push_case1(1'b1);
        run(1'b1, 1'b0, 6);
        check("c2_writes", 32'(run_wr), 32'd12);
        check_case1_mem(1'b1, 1'b0);
        finish_run();

        // case 3a: NUM=0
        for (int k = 0; k < 128; k++) mem[k] = 32'h0;
        run(1'b0, 1'b0, 0);
        check("n0_writes", 32'(run_wr), 32'd0);
        check("n0_macs", 32'(run_mac), 32'd0);
        check("n0_done", {31'h0, DONE}, 32'd1);
        finish_run();

        // case 3b: NUM=15 clamps to 10 bodies
        mem[1] = 32'd15;
        for (int i = 0; i < 10; i++)
            for (int d = 0; d < 3; d++) push_wr(32'(53 + d * 10 + i + 1), ZERO);
        for (int i = 0; i < 10; i++)
            for (int d = 0; d < 3; d++) push_wr(32'(23 + d * 10 + i + 1), ZERO);
        run(1'b0, 1'b0, 30);
        check("n15_writes", 32'(run_wr), 32'd60);
        check("n15_macs", 32'(run_mac), 32'd60);
        finish_run();

        // case 4: clear accelerations afterwards
        load_case1();
        push_case1(1'b0);
        for (int k = 0; k < 6; k++) push_wr(clr_a[k], ZERO);
        run(1'b0, 1'b1, 6);
        check("clr_writes", 32'(run_wr), 32'd18);
        check("clr_done_gap", 32'(done_gap), 32'd1);
        check_case1_mem(1'b0, 1'b1);
        check("mem_acc0y", mem[94], ZERO);
        finish_run();

        // case 5: reset with two MACs in flight
        load_case1();
        sb_on  = 1'b0;
        per_phase = 0;
        MODE   = 1'b0;
        clr_acc_en = 1'b0;
        START  = 1'b1;
        issued = 0;
        for (int t = 0; t < 200 && issued < 2; t++) begin
            @(negedge CLK);
            if (mac_valid_in) issued++;
        end
        check("rst_two_issued", 32'(issued), 32'd2);
        RESET = 1'b1;
        START = 1'b0;
        @(negedge CLK);
        check("rst_mid_outs", {rd_addr | wr_addr | wr_data | mac_a | mac_b | mac_c}, 32'h0);
        check("rst_mid_flags", {28'h0, wr_en, mac_valid_in, BUSY, DONE}, 32'h0);
        RESET   = 1'b0;
        wr_seen = 0;
        repeat (LAT) begin
            @(negedge CLK);
            if (wr_en) wr_seen++;
        end
        check("rst_no_wr", 32'(wr_seen), 32'd0);
        sb_on = 1'b1;
        push_case1(1'b0);
        run(1'b0, 1'b0, 6);
        check("rst_rerun_writes", 32'(run_wr), 32'd12);
        check_case1_mem(1'b0, 1'b0);
        finish_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
